mux_scanner: RTL

- Sequencer placed around the team's 4:1 single-bit multiplexer. It drives the mux select `s` and samples the mux output `mux_out`.
- It steps through all four channels, holding each one for DWELL cycles so the mux output can settle.
- It assembles the four samples into a 4-bit parallel word and signals each completed sweep with a one-cycle valid pulse.
- It supports single-shot and continuous scanning, with a graceful stop.

---
 rtl/mux_scanner.sv | 110 +++++++++++
 1 files changed

// File: rtl/mux_scanner.sv
// Steps a 4:1 mux select through all channels and packs the four samples into a parallel word.
// Latency: channel k is sampled DWELL*(k+1) edges after start is accepted; word_valid follows the last sample edge.
// Backpressure: none; start is taken only in IDLE, and stop ends a continuous scan after the current sweep.
module mux_scanner #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic             mux_out,
    output logic [1:0]       s,
    output logic             busy,
    output logic [3:0]       word,
    output logic             word_valid,
    output logic [CNT_W-1:0] scan_count
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [3:0] DLAST = 4'(DWELL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ch;
    logic [3:0] dcnt;
    logic       cont_r;
    logic       stop_req;
    logic [2:0] shadow;

    logic       accept;
    logic       sample;
    logic       last;
    logic       keep_going;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last && !keep_going) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ch is a register and is forced back to 0 on leaving SCAN, so s is glitch-free and 00 in IDLE.
    always_comb begin
        accept     = (state == IDLE) && start;
        sample     = (state == SCAN) && (dcnt == DLAST);
        last       = sample && (ch == 2'd3);
        keep_going = cont_r && !stop_req && !stop;
        busy       = (state == SCAN);
        s          = ch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch         <= 2'd0;
            dcnt       <= 4'd0;
            cont_r     <= 1'b0;
            stop_req   <= 1'b0;
            shadow     <= 3'b000;
            word       <= 4'b0000;
            word_valid <= 1'b0;
            scan_count <= '0;
        end else begin
            word_valid <= 1'b0;
            if (accept) begin
                ch       <= 2'd0;
                dcnt     <= 4'd0;
                cont_r   <= cont;
                stop_req <= 1'b0;
            end else if (state == SCAN) begin
                if (stop) begin
                    stop_req <= 1'b1;
                end
                if (!sample) begin
                    dcnt <= dcnt + 4'd1;
                end else begin
                    dcnt <= 4'd0;
                    if (ch != 2'd3) begin
                        for (int i = 0; i < 3; i++) begin
                            if (ch == 2'(i)) shadow[i] <= mux_out;
                        end
                        ch <= ch + 2'd1;
                    end else begin
                        word       <= {mux_out, shadow};
                        word_valid <= 1'b1;
                        scan_count <= scan_count + CNT_W'(1);
                        ch         <= 2'd0;
                        // A stop seen on this very edge also ends the scan; clear the request on the way out.
                        if (!keep_going) begin
                            stop_req <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
